// File: rtl/sad_block_accumulator_if.sv
// Pixel-pair input and block-result output handshakes of the SAD accumulator.
// master = producer/consumer side, slave = accumulator side.
interface sad_block_accumulator_if #(
   parameter int PIX_W = 3,
   parameter int ACC_W = 6
);
   logic [PIX_W-1:0] I0;
   logic [PIX_W-1:0] I1;
   logic             I_VALID;
   logic             I_READY;
   logic [ACC_W-1:0] O;
   logic             O_VALID;
   logic             O_READY;

   modport master (output I0, I1, I_VALID, O_READY, input I_READY, O, O_VALID);
   modport slave  (input I0, I1, I_VALID, O_READY, output I_READY, O, O_VALID);
endinterface

// File: rtl/sad_block_accumulator.sv
// Streaming SAD: sums |I0-I1| over BLOCK_LEN accepted pairs and holds the
// block result on a valid/ready output until consumed.
module sad_block_accumulator #(
   parameter int PIX_W     = 3,
   parameter int BLOCK_LEN = 8,
   localparam int ACC_W    = PIX_W + $clog2(BLOCK_LEN),
   localparam int CNT_W    = $clog2(BLOCK_LEN)
) (
   input  logic                   CLK,
   input  logic                   ASYNCRESET,
   input  logic                   CLR,
   sad_block_accumulator_if.slave bus
);
   typedef enum logic {ACCUM, HOLD} state_t;

   localparam logic [CNT_W-1:0] LAST = CNT_W'(BLOCK_LEN - 1);

   state_t           r_state, w_state_nxt;
   logic [ACC_W-1:0] r_acc, w_acc_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic [ACC_W-1:0] r_o, w_o_nxt;

   logic [PIX_W-1:0] w_diff;
   logic [ACC_W-1:0] w_diff_ext;
   logic             w_ready;
   logic             w_accept;

   assign w_diff     = (bus.I0 >= bus.I1) ? bus.I0 - bus.I1 : bus.I1 - bus.I0;
   assign w_diff_ext = {{(ACC_W-PIX_W){1'b0}}, w_diff};

   // In HOLD the input side is only open when the result leaves this cycle.
   assign w_ready  = (r_state == ACCUM) | bus.O_READY;
   assign w_accept = bus.I_VALID & w_ready;

   assign bus.I_READY = w_ready;
   assign bus.O       = r_o;
   assign bus.O_VALID = (r_state == HOLD);

   always_ff @(posedge CLK or posedge ASYNCRESET) begin
      if (ASYNCRESET) begin
         r_state <= ACCUM;
         r_acc   <= '0;
         r_cnt   <= '0;
         r_o     <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_acc   <= w_acc_nxt;
         r_cnt   <= w_cnt_nxt;
         r_o     <= w_o_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_acc_nxt   = r_acc;
      w_cnt_nxt   = r_cnt;
      w_o_nxt     = r_o;
      if (CLR) begin
         // Restart discards any pair presented this cycle; O keeps its value.
         w_state_nxt = ACCUM;
         w_acc_nxt   = '0;
         w_cnt_nxt   = '0;
      end else begin
         case (r_state)
            ACCUM: begin
               if (w_accept) begin
                  if (r_cnt == LAST) begin
                     w_o_nxt     = r_acc + w_diff_ext;
                     w_acc_nxt   = '0;
                     w_cnt_nxt   = '0;
                     w_state_nxt = HOLD;
                  end else begin
                     w_acc_nxt = r_acc + w_diff_ext;
                     w_cnt_nxt = r_cnt + CNT_W'(1);
                  end
               end
            end
            HOLD: begin
               if (bus.O_READY) begin
                  w_state_nxt = ACCUM;
                  if (bus.I_VALID) begin
                     w_acc_nxt = w_diff_ext;
                     w_cnt_nxt = CNT_W'(1);
                  end else begin
                     w_acc_nxt = '0;
                     w_cnt_nxt = '0;
                  end
               end
            end
            default: w_state_nxt = ACCUM;
         endcase
      end
   end
endmodule

// File: tb/tb_sad_block_accumulator.sv
// Bench for sad_block_accumulator: directed scenarios plus random traffic
// against a queue-based block-sum model.
module tb_sad_block_accumulator;
   localparam int PIX_W     = 3;
   localparam int BLOCK_LEN = 8;
   localparam int ACC_W     = PIX_W + $clog2(BLOCK_LEN);

   logic CLK = 1'b0;
   logic ASYNCRESET = 1'b1;
   logic CLR = 1'b0;

   sad_block_accumulator_if #(.PIX_W(PIX_W), .ACC_W(ACC_W)) bus ();

   sad_block_accumulator #(.PIX_W(PIX_W), .BLOCK_LEN(BLOCK_LEN)) dut (
      .CLK(CLK), .ASYNCRESET(ASYNCRESET), .CLR(CLR), .bus(bus)
   );

   always #5 CLK = ~CLK;

   int checks = 0;
   int errors = 0;

   // Model: diffs accepted in the open block, held flag, last result.
   int blk[$];
   bit m_hold = 0;
   int m_o = 0;

   task automatic model_reset();
      blk.delete();
      m_hold = 0;
      m_o = 0;
   endtask

   // Drive one cycle at the falling edge, advance the model, return #1 after the rising edge.
   task automatic step(input bit v, input int a, input int b, input bit ordy, input bit clr);
      int d, s;
      @(negedge CLK);
      bus.I_VALID = v;
      bus.I0      = PIX_W'(a);
      bus.I1      = PIX_W'(b);
      bus.O_READY = ordy;
      CLR         = clr;
      d = (a >= b) ? a - b : b - a;
      if (clr) begin
         blk.delete();
         m_hold = 0;
      end else if (m_hold) begin
         if (ordy) begin
            m_hold = 0;
            blk.delete();
            if (v) blk.push_back(d);
         end
      end else if (v) begin
         blk.push_back(d);
         if (blk.size() == BLOCK_LEN) begin
            s = 0;
            foreach (blk[i]) s += blk[i];
            m_o = s;
            m_hold = 1;
            blk.delete();
         end
      end
      @(posedge CLK);
      #1;
      CLR = 1'b0;
   endtask

   task automatic test_reset();
      #2;
      checks++;
      if (bus.O !== '0 || bus.O_VALID !== 1'b0) begin
         errors++;
         $display("FAIL reset_state O=%0d O_VALID=%b required O=0 O_VALID=0", bus.O, bus.O_VALID);
      end
      @(negedge CLK);
      ASYNCRESET = 1'b0;
      model_reset();
      #1;
      checks++;
      if (bus.I_READY !== 1'b1) begin
         errors++;
         $display("FAIL reset_ready I_READY=%b required 1", bus.I_READY);
      end
   endtask

   task automatic test_basic();
      for (int i = 0; i < BLOCK_LEN; i++) begin
         step(1, 0, 2, 0, 0);
         if (i == BLOCK_LEN - 2) begin
            checks++;
            if (bus.O_VALID !== 1'b0) begin
               errors++;
               $display("FAIL basic_early O_VALID=%b required 0", bus.O_VALID);
            end
         end
      end
      checks++;
      if (bus.O_VALID !== 1'b1 || bus.O !== ACC_W'(16)) begin
         errors++;
         $display("FAIL basic_result O=%0d O_VALID=%b required O=16 O_VALID=1", bus.O, bus.O_VALID);
      end
      for (int i = 0; i < 5; i++) begin
         step(0, 0, 0, 0, 0);
         checks++;
         if (bus.I_READY !== 1'b0 || bus.O !== ACC_W'(16) || bus.O_VALID !== 1'b1) begin
            errors++;
            $display("FAIL basic_hold I_READY=%b O=%0d O_VALID=%b required 0/16/1", bus.I_READY, bus.O, bus.O_VALID);
         end
      end
      step(0, 0, 0, 1, 0);
      checks++;
      if (bus.O_VALID !== 1'b0) begin
         errors++;
         $display("FAIL basic_consume O_VALID=%b required 0", bus.O_VALID);
      end
   endtask

   task automatic test_extremes();
      for (int i = 0; i < 4; i++) step(1, 7, 0, 0, 0);
      for (int i = 0; i < 4; i++) step(1, 0, 7, 0, 0);
      checks++;
      if (bus.O_VALID !== 1'b1 || bus.O !== ACC_W'(56)) begin
         errors++;
         $display("FAIL extremes_max O=%0d O_VALID=%b required O=56 O_VALID=1", bus.O, bus.O_VALID);
      end
      step(0, 0, 0, 1, 0);
      for (int i = 0; i < BLOCK_LEN; i++) step(1, 3, 3, 0, 0);
      checks++;
      if (bus.O_VALID !== 1'b1 || bus.O !== ACC_W'(0)) begin
         errors++;
         $display("FAIL extremes_zero O=%0d O_VALID=%b required O=0 O_VALID=1", bus.O, bus.O_VALID);
      end
      step(0, 0, 0, 1, 0);
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 2 * BLOCK_LEN - 1; i++) begin
         step((i % 2) == 0, 5, 1, 0, 0);
         if (i == 2 * BLOCK_LEN - 3) begin
            checks++;
            if (bus.O_VALID !== 1'b0) begin
               errors++;
               $display("FAIL stall_early O_VALID=%b required 0", bus.O_VALID);
            end
         end
      end
      checks++;
      if (bus.O_VALID !== 1'b1 || bus.O !== ACC_W'(32)) begin
         errors++;
         $display("FAIL stall_result O=%0d O_VALID=%b required O=32 O_VALID=1", bus.O, bus.O_VALID);
      end
      step(1, 6, 2, 1, 0);
      checks++;
      if (bus.O_VALID !== 1'b0) begin
         errors++;
         $display("FAIL b2b_transfer O_VALID=%b required 0", bus.O_VALID);
      end
      for (int i = 0; i < BLOCK_LEN - 1; i++) begin
         step(1, 1, 0, 0, 0);
         if (i == BLOCK_LEN - 3) begin
            checks++;
            if (bus.O_VALID !== 1'b0) begin
               errors++;
               $display("FAIL b2b_early O_VALID=%b required 0", bus.O_VALID);
            end
         end
      end
      checks++;
      if (bus.O_VALID !== 1'b1 || bus.O !== ACC_W'(11)) begin
         errors++;
         $display("FAIL b2b_result O=%0d O_VALID=%b required O=11 O_VALID=1", bus.O, bus.O_VALID);
      end
      step(0, 0, 0, 1, 0);
   endtask

   task automatic test_clr();
      for (int i = 0; i < 5; i++) step(1, 4, 0, 0, 0);
      step(1, 7, 0, 0, 1);
      checks++;
      if (bus.O_VALID !== 1'b0) begin
         errors++;
         $display("FAIL clr_valid O_VALID=%b required 0", bus.O_VALID);
      end
      for (int i = 0; i < BLOCK_LEN; i++) begin
         step(1, 1, 0, 0, 0);
         if (i == BLOCK_LEN - 2) begin
            checks++;
            if (bus.O_VALID !== 1'b0) begin
               errors++;
               $display("FAIL clr_early O_VALID=%b required 0", bus.O_VALID);
            end
         end
      end
      checks++;
      if (bus.O_VALID !== 1'b1 || bus.O !== ACC_W'(8)) begin
         errors++;
         $display("FAIL clr_result O=%0d O_VALID=%b required O=8 O_VALID=1", bus.O, bus.O_VALID);
      end
      step(0, 0, 0, 1, 0);
   endtask

   task automatic test_reset_hold();
      for (int i = 0; i < BLOCK_LEN; i++) step(1, 3, 0, 0, 0);
      checks++;
      if (bus.O_VALID !== 1'b1 || bus.O !== ACC_W'(24)) begin
         errors++;
         $display("FAIL rsthold_pre O=%0d O_VALID=%b required O=24 O_VALID=1", bus.O, bus.O_VALID);
      end
      @(negedge CLK);
      bus.I_VALID = 1'b0;
      #2;
      ASYNCRESET = 1'b1;
      #1;
      checks++;
      if (bus.O !== '0 || bus.O_VALID !== 1'b0) begin
         errors++;
         $display("FAIL rsthold_async O=%0d O_VALID=%b required O=0 O_VALID=0", bus.O, bus.O_VALID);
      end
      @(negedge CLK);
      ASYNCRESET = 1'b0;
      model_reset();
      for (int i = 0; i < BLOCK_LEN; i++) step(1, 2, 0, 0, 0);
      checks++;
      if (bus.O_VALID !== 1'b1 || bus.O !== ACC_W'(16)) begin
         errors++;
         $display("FAIL rsthold_fresh O=%0d O_VALID=%b required O=16 O_VALID=1", bus.O, bus.O_VALID);
      end
      step(0, 0, 0, 1, 0);
   endtask

   task automatic test_random();
      bit v, r, c;
      int a, b;
      for (int n = 0; n < 400; n++) begin
         v = 1'($urandom_range(0, 1));
         r = 1'($urandom_range(0, 3) == 0);
         c = 1'($urandom_range(0, 31) == 0);
         a = $urandom_range(0, 7);
         b = $urandom_range(0, 7);
         step(v, a, b, r, c);
         checks++;
         if (bus.O_VALID !== m_hold || bus.O !== ACC_W'(m_o) || bus.I_READY !== (!m_hold || r)) begin
            errors++;
            $display("FAIL random_%0d O=%0d O_VALID=%b I_READY=%b required O=%0d O_VALID=%b I_READY=%b",
                     n, bus.O, bus.O_VALID, bus.I_READY, m_o, m_hold, (!m_hold || r));
         end
      end
   endtask

   initial begin
      bus.I0 = '0;
      bus.I1 = '0;
      bus.I_VALID = 1'b0;
      bus.O_READY = 1'b0;
      test_reset();
      test_basic();
      test_extremes();
      test_back_to_back();
      test_clr();
      test_reset_hold();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
